// File: rtl/regfile_wr_if.sv
// regfile_wr_if: valid/ready request bundle between requesters and the
// register-file write-port arbiter.
interface regfile_wr_if #(
  parameter int N_REQ = 3,
  parameter int AW    = 5,
  parameter int DW    = 32
);
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ*AW-1:0] req_addr;
  logic [N_REQ*DW-1:0] req_data;
  logic [N_REQ-1:0]    req_ready;

  modport master (
    output req_valid,
    output req_addr,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_data,
    output req_ready
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: round-robin owner of the regfile write port.
// Define REGFILE_CLR_EN to sweep-clear x1..x31 after every reset.
module regfile_wr_arbiter #(
  parameter int N_REQ = 3,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  regfile_wr_if.slave   bus,
  output logic          we,
  output logic [AW-1:0] wa,
  output logic [DW-1:0] wd,
  output logic [1:0]    grant_id,
  output logic          init_done
);

`ifdef REGFILE_CLR_EN
  localparam logic [AW-1:0] LAST = '1;

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_t;

  state_t        state, state_nx;
  logic [AW-1:0] cnt, cnt_nx;
`endif

  logic [1:0]       ptr, ptr_nx;
  logic [1:0]       sel;
  logic             hit;
  logic             xfer;
  logic [N_REQ-1:0] gnt;
  logic [AW-1:0]    sel_addr;
  logic [DW-1:0]    sel_data;

  logic          we_nx;
  logic [AW-1:0] wa_nx;
  logic [DW-1:0] wd_nx;
  logic [1:0]    gid_nx;
  logic          init_nx;

  // first valid requester at or after ptr, wrapping
  always_comb begin
    int j;
    sel = '0;
    hit = 1'b0;
    j   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = (int'(ptr) + k) % N_REQ;
      if (!hit && bus.req_valid[j]) begin
        hit = 1'b1;
        sel = 2'(j);
      end
    end
  end

  assign xfer = hit && init_done;

  always_comb begin
    gnt = '0;
    for (int i = 0; i < N_REQ; i++)
      gnt[i] = xfer && (sel == 2'(i));
  end

  assign bus.req_ready = gnt;
  assign sel_addr = bus.req_addr[int'(sel)*AW +: AW];
  assign sel_data = bus.req_data[int'(sel)*DW +: DW];

  always_comb begin
    we_nx  = 1'b0;
    wa_nx  = wa;
    wd_nx  = wd;
    gid_nx = grant_id;
    ptr_nx = ptr;
`ifdef REGFILE_CLR_EN
    state_nx = state;
    cnt_nx   = cnt;
    init_nx  = (state == S_RUN);
    if (state == S_INIT) begin
      we_nx  = 1'b1;
      wa_nx  = cnt;
      wd_nx  = '0;
      cnt_nx = cnt + 1'b1;
      if (cnt == LAST)
        state_nx = S_RUN;
    end
`else
    init_nx = 1'b1;
`endif
    if (xfer) begin
      we_nx  = (sel_addr != '0);
      wa_nx  = sel_addr;
      wd_nx  = sel_data;
      gid_nx = sel;
      ptr_nx = (int'(sel) == N_REQ - 1) ? 2'd0 : sel + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we        <= 1'b0;
      wa        <= '0;
      wd        <= '0;
      grant_id  <= '0;
      init_done <= 1'b0;
      ptr       <= '0;
`ifdef REGFILE_CLR_EN
      state     <= S_INIT;
      cnt       <= AW'(1);
`endif
    end else begin
      we        <= we_nx;
      wa        <= wa_nx;
      wd        <= wd_nx;
      grant_id  <= gid_nx;
      init_done <= init_nx;
      ptr       <= ptr_nx;
`ifdef REGFILE_CLR_EN
      state     <= state_nx;
      cnt       <= cnt_nx;
`endif
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb_regfile_wr_arbiter: directed + random bench with a write scoreboard.
// Covers both builds of REGFILE_CLR_EN.
module tb_regfile_wr_arbiter;
  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [1:0]    gid;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          we;
  logic [AW-1:0] wa;
  logic [DW-1:0] wd;
  logic [1:0]    grant_id;
  logic          init_done;

  int   n_vec = 0;
  int   n_err = 0;
  wr_t  sb[$];
  wr_t  m_last;
  logic [1:0] m_ptr;

  regfile_wr_if #(.N_REQ(N), .AW(AW), .DW(DW)) bus ();

  regfile_wr_arbiter #(.N_REQ(N), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .we        (we),
    .wa        (wa),
    .wd        (wd),
    .grant_id  (grant_id),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, "_we"}, 64'(we), 64'(0));
    chk({tag, "_wa"}, 64'(wa), 64'(0));
    chk({tag, "_wd"}, 64'(wd), 64'(0));
    chk({tag, "_gid"}, 64'(grant_id), 64'(0));
    chk({tag, "_init"}, 64'(init_done), 64'(0));
    chk({tag, "_ready"}, 64'(bus.req_ready), 64'(0));
  endtask

  task automatic sweep(input int upto);
    for (int k = 1; k <= upto; k++) begin
      @(posedge clk); #1;
      chk($sformatf("sweep_%0d", k),
          {init_done, bus.req_ready, we, wa, wd},
          {1'b0, 3'b000, 1'b1, 5'(k), 32'h0});
    end
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_pre_edge", 64'(bus.req_ready), 64'(0));
  endtask

  task automatic start();
    bus.req_valid = '1;
    release_rst();
    m_ptr  = '0;
    m_last = '0;
`ifdef REGFILE_CLR_EN
    sweep(31);
    @(posedge clk); #1;
    chk("init_done_c32", 64'(init_done), 64'(1));
    chk("we_c32", 64'(we), 64'(0));
    m_last.wa = 5'd31;
`else
    @(posedge clk); #1;
    chk("init_done_c1", 64'(init_done), 64'(1));
    chk("we_c1", 64'(we), 64'(0));
`endif
  endtask

  task automatic cycle(input string tag, input logic [N-1:0] v,
                       input logic [N*AW-1:0] a, input logic [N*DW-1:0] d);
    logic [N-1:0] r;
    wr_t e;
    wr_t got;
    int  j;
    bit  hit;
    bus.req_valid = v;
    bus.req_addr  = a;
    bus.req_data  = d;
    #1;
    r   = '0;
    hit = 1'b0;
    e   = m_last;
    e.we = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = (int'(m_ptr) + k) % N;
      if (!hit && v[j]) begin
        hit   = 1'b1;
        r[j]  = 1'b1;
        e.wa  = a[j*AW +: AW];
        e.wd  = d[j*DW +: DW];
        e.gid = 2'(j);
        e.we  = (e.wa != '0);
        m_ptr = (j == N - 1) ? 2'd0 : 2'(j + 1);
      end
    end
    chk({tag, "_ready"}, 64'(bus.req_ready), 64'(r));
    sb.push_back(e);
    m_last = e;
    @(posedge clk); #1;
    got = {we, wa, wd, grant_id};
    e = sb.pop_front();
    chk({tag, "_write"}, 64'(got), 64'(e));
  endtask

  initial begin
    bus.req_valid = '1;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    m_ptr  = '0;
    m_last = '0;
    #12;
    rst_chk("por");

`ifdef REGFILE_CLR_EN
    release_rst();
    sweep(10);
    #2 rst_n = 1'b0;
    #1 rst_chk("rst_sweep");
`endif

    start();
    cycle("first_r0", 3'b001, {5'd0, 5'd0, 5'd7},
          {32'h0, 32'h0, 32'hA5A5_0001});
    cycle("idle0", 3'b000, '0, '0);
    cycle("single_r1", 3'b010, {5'd0, 5'd5, 5'd0},
          {32'h0, 32'hDEAD_BEEF, 32'h0});
    cycle("idle1", 3'b000, '0, '0);
    cycle("x0_r2", 3'b100, {5'd0, 5'd0, 5'd0},
          {32'h0000_1234, 32'h0, 32'h0});

    for (int i = 0; i < 6; i++)
      cycle($sformatf("rr_%0d", i), 3'b111,
            {5'(20 + i), 5'(10 + i), 5'(1 + i)},
            {32'(300 + i), 32'(200 + i), 32'(100 + i)});
    cycle("idle2", 3'b000, '0, '0);

    for (int i = 0; i < 24; i++)
      cycle($sformatf("rnd_%0d", i), 3'($urandom_range(0, 7)),
            15'($urandom), {$urandom, $urandom, $urandom});

    cycle("pre_rst", 3'b001, {5'd0, 5'd0, 5'd9},
          {32'h0, 32'h0, 32'h0BAD_F00D});
    bus.req_valid = '1;
    #2 rst_n = 1'b0;
    #1 rst_chk("rst_run");
    @(posedge clk); #1;
    start();
    cycle("ptr_reset", 3'b110, {5'd4, 5'd3, 5'd0},
          {32'h2222, 32'h1111, 32'h0});
    cycle("idle3", 3'b000, '0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
